hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl_pkg.sv | 42 ++++
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/hazard_ctrl_detect.sv | 34 +++
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// stall-bus layout, FSM state encoding, bubble strobes and the register-match rule.
package hazard_ctrl_pkg;

    localparam int unsigned STALL_W   = 6;
    localparam int unsigned STALL_PC  = 0;
    localparam int unsigned STALL_IF  = 1;
    localparam int unsigned STALL_ID  = 2;
    localparam int unsigned STALL_EX  = 3;
    localparam int unsigned STALL_MEM = 4;
    localparam int unsigned STALL_WB  = 5;

    typedef logic [STALL_W-1:0] stall_bus_t;
    typedef logic [4:0]         reg_addr_t;

    localparam stall_bus_t STALL_NONE     = '0;
    localparam stall_bus_t STALL_LOAD_USE = stall_bus_t'((1 << STALL_PC) | (1 << STALL_IF) | (1 << STALL_ID));
    localparam stall_bus_t STALL_EX_HOLD  = STALL_LOAD_USE | stall_bus_t'(1 << STALL_EX);
    // MEM/WB always drain: this controller never holds them.
    localparam stall_bus_t STALL_BACK     = stall_bus_t'((1 << STALL_MEM) | (1 << STALL_WB));

    typedef struct packed {
        logic ex;
        logic mem;
    } bubble_t;

    localparam bubble_t BUBBLE_NONE = '{ex: 1'b0, mem: 1'b0};
    localparam bubble_t BUBBLE_EX   = '{ex: 1'b1, mem: 1'b0};
    localparam bubble_t BUBBLE_MEM  = '{ex: 1'b0, mem: 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LU_WAIT = 2'd1,
        ST_EX_HOLD = 2'd2
    } state_e;

    // r0 is hard-wired zero, so it never carries a dependency.
    function automatic logic reg_match(input logic re, input reg_addr_t raddr, input reg_addr_t waddr);
        return re && (raddr != '0) && (raddr == waddr);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID/EX/MEM-side signal bundle for the hazard controller; the pipeline is the master,
// the controller the slave.
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic       flush;
    logic       id_re1;
    reg_addr_t  id_raddr1;
    logic       id_re2;
    reg_addr_t  id_raddr2;
    logic       ex_wreg;
    reg_addr_t  ex_waddr;
    logic       ex_is_load;
    logic       mem_wreg;
    reg_addr_t  mem_waddr;
    logic       mem_is_load;
    logic       ex_busy;
    stall_bus_t stall;
    logic       ex_bubble;
    logic       mem_bubble;
    logic [31:0] stall_cycles;

    modport master (
        output flush, id_re1, id_raddr1, id_re2, id_raddr2,
        output ex_wreg, ex_waddr, ex_is_load,
        output mem_wreg, mem_waddr, mem_is_load, ex_busy,
        input  stall, ex_bubble, mem_bubble, stall_cycles
    );

    modport slave (
        input  flush, id_re1, id_raddr1, id_re2, id_raddr2,
        input  ex_wreg, ex_waddr, ex_is_load,
        input  mem_wreg, mem_waddr, mem_is_load, ex_busy,
        output stall, ex_bubble, mem_bubble, stall_cycles
    );

endinterface

// File: rtl/hazard_ctrl_detect.sv
// Combinational load-use detection: compares ID read ports against the EX and MEM
// destination tags of in-flight loads.
module hazard_ctrl_detect
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 2
) (
    input  logic      id_re1_i,
    input  reg_addr_t id_raddr1_i,
    input  logic      id_re2_i,
    input  reg_addr_t id_raddr2_i,
    input  logic      ex_wreg_i,
    input  reg_addr_t ex_waddr_i,
    input  logic      ex_is_load_i,
    input  logic      mem_wreg_i,
    input  reg_addr_t mem_waddr_i,
    input  logic      mem_is_load_i,
    output logic      haz_ex_o,
    output logic      haz_mem_o
);

    logic match_ex;
    logic match_mem;

    assign match_ex  = reg_match(id_re1_i, id_raddr1_i, ex_waddr_i)
                     | reg_match(id_re2_i, id_raddr2_i, ex_waddr_i);
    assign match_mem = reg_match(id_re1_i, id_raddr1_i, mem_waddr_i)
                     | reg_match(id_re2_i, id_raddr2_i, mem_waddr_i);

    assign haz_ex_o  = ex_wreg_i & ex_is_load_i & match_ex;
    // With a one-cycle load the MEM-stage result is already on the bypass path.
    assign haz_mem_o = (LOAD_LAT > 1) & mem_wreg_i & mem_is_load_i & match_mem;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/bubble controller: load-use and multi-cycle-EX hold FSM with a
// zero-latency stall vector and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned CNT_W    = 3
) (
    input logic         clk,
    input logic         resetn,
    hazard_ctrl_if.slave bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      stall_cycles_q, stall_cycles_d;

    logic       haz_ex;
    logic       haz_mem;
    stall_bus_t stall_raw;
    bubble_t    bubble_raw;
    stall_bus_t stall_out;

    hazard_ctrl_detect #(
        .LOAD_LAT (LOAD_LAT)
    ) u_detect (
        .id_re1_i      (bus.id_re1),
        .id_raddr1_i   (bus.id_raddr1),
        .id_re2_i      (bus.id_re2),
        .id_raddr2_i   (bus.id_raddr2),
        .ex_wreg_i     (bus.ex_wreg),
        .ex_waddr_i    (bus.ex_waddr),
        .ex_is_load_i  (bus.ex_is_load),
        .mem_wreg_i    (bus.mem_wreg),
        .mem_waddr_i   (bus.mem_waddr),
        .mem_is_load_i (bus.mem_is_load),
        .haz_ex_o      (haz_ex),
        .haz_mem_o     (haz_mem)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_raw  = STALL_NONE;
        bubble_raw = BUBBLE_NONE;

        if (bus.flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.ex_busy) begin
                        stall_raw  = STALL_EX_HOLD;
                        bubble_raw = BUBBLE_MEM;
                        state_d    = ST_EX_HOLD;
                    end else if (haz_ex) begin
                        stall_raw  = STALL_LOAD_USE;
                        bubble_raw = BUBBLE_EX;
                        cnt_d      = CNT_W'(LOAD_LAT - 1);
                        state_d    = (LOAD_LAT > 1) ? ST_LU_WAIT : ST_IDLE;
                    end else if (haz_mem) begin
                        // The detect cycle is itself a stall cycle, so a MEM-stage
                        // load needs one fewer wait cycle than an EX-stage one.
                        stall_raw  = STALL_LOAD_USE;
                        bubble_raw = BUBBLE_EX;
                        cnt_d      = CNT_W'(LOAD_LAT - 2);
                        state_d    = (LOAD_LAT > 2) ? ST_LU_WAIT : ST_IDLE;
                    end
                end
                ST_LU_WAIT: begin
                    stall_raw  = STALL_LOAD_USE;
                    bubble_raw = BUBBLE_EX;
                    cnt_d      = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_EX_HOLD: begin
                    if (bus.ex_busy) begin
                        stall_raw  = STALL_EX_HOLD;
                        bubble_raw = BUBBLE_MEM;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign stall_out = resetn ? (stall_raw & ~STALL_BACK) : STALL_NONE;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if ((stall_out != STALL_NONE) && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    assign bus.stall        = stall_out;
    assign bus.ex_bubble    = resetn & bubble_raw.ex;
    assign bus.mem_bubble   = resetn & bubble_raw.mem;
    assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: cycle-by-cycle vector table with a scoreboard
// on a LOAD_LAT=2 instance, plus short load-use sequences on a LOAD_LAT=3 instance.
module tb_hazard_ctrl;

    typedef struct {
        logic       rstn;
        logic       flush;
        logic       re1;
        logic [4:0] ra1;
        logic       re2;
        logic [4:0] ra2;
        logic       exw;
        logic [4:0] exa;
        logic       exl;
        logic       memw;
        logic [4:0] mema;
        logic       meml;
        logic       busy;
        logic [5:0] stall;
        logic       exb;
        logic       memb;
    } vec_t;

    typedef struct {
        int          id;
        logic [5:0]  stall;
        logic        exb;
        logic        memb;
        logic [31:0] cyc;
    } exp_t;

    localparam int LU = 7;   // 000111
    localparam int EH = 15;  // 001111

    logic        clk = 1'b0;
    logic        resetn;
    vec_t        cur;
    exp_t        sb[$];
    vec_t        tbl[$];
    logic [31:0] exp_cnt;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if bus_a ();
    hazard_ctrl_if bus_b ();

    hazard_ctrl #(.LOAD_LAT(2), .CNT_W(3)) dut_a (.clk(clk), .resetn(resetn), .bus(bus_a));
    hazard_ctrl #(.LOAD_LAT(3), .CNT_W(3)) dut_b (.clk(clk), .resetn(resetn), .bus(bus_b));

    assign resetn = cur.rstn;

    assign bus_a.flush       = cur.flush;
    assign bus_a.id_re1      = cur.re1;
    assign bus_a.id_raddr1   = cur.ra1;
    assign bus_a.id_re2      = cur.re2;
    assign bus_a.id_raddr2   = cur.ra2;
    assign bus_a.ex_wreg     = cur.exw;
    assign bus_a.ex_waddr    = cur.exa;
    assign bus_a.ex_is_load  = cur.exl;
    assign bus_a.mem_wreg    = cur.memw;
    assign bus_a.mem_waddr   = cur.mema;
    assign bus_a.mem_is_load = cur.meml;
    assign bus_a.ex_busy     = cur.busy;

    assign bus_b.flush       = cur.flush;
    assign bus_b.id_re1      = cur.re1;
    assign bus_b.id_raddr1   = cur.ra1;
    assign bus_b.id_re2      = cur.re2;
    assign bus_b.id_raddr2   = cur.ra2;
    assign bus_b.ex_wreg     = cur.exw;
    assign bus_b.ex_waddr    = cur.exa;
    assign bus_b.ex_is_load  = cur.exl;
    assign bus_b.mem_wreg    = cur.memw;
    assign bus_b.mem_waddr   = cur.mema;
    assign bus_b.mem_is_load = cur.meml;
    assign bus_b.ex_busy     = cur.busy;

    function automatic vec_t mk(input int rstn, input int flush,
                                input int re1, input int ra1, input int re2, input int ra2,
                                input int exw, input int exa, input int exl,
                                input int memw, input int mema, input int meml,
                                input int busy, input int st, input int exb, input int memb);
        vec_t v;
        v.rstn  = (rstn != 0);
        v.flush = (flush != 0);
        v.re1   = (re1 != 0);
        v.ra1   = 5'(ra1);
        v.re2   = (re2 != 0);
        v.ra2   = 5'(ra2);
        v.exw   = (exw != 0);
        v.exa   = 5'(exa);
        v.exl   = (exl != 0);
        v.memw  = (memw != 0);
        v.mema  = 5'(mema);
        v.meml  = (meml != 0);
        v.busy  = (busy != 0);
        v.stall = 6'(st);
        v.exb   = (exb != 0);
        v.memb  = (memb != 0);
        return v;
    endfunction

    task automatic check_a();
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL scoreboard: empty queue, no expected record to compare");
        end else begin
            e = sb.pop_front();
            if (bus_a.stall !== e.stall || bus_a.ex_bubble !== e.exb ||
                bus_a.mem_bubble !== e.memb || bus_a.stall_cycles !== e.cyc) begin
                fails++;
                $display("FAIL step%0d: got stall=%b exb=%b memb=%b cyc=%h, required stall=%b exb=%b memb=%b cyc=%h",
                         e.id, bus_a.stall, bus_a.ex_bubble, bus_a.mem_bubble, bus_a.stall_cycles,
                         e.stall, e.exb, e.memb, e.cyc);
            end
        end
    endtask

    task automatic apply(input int id, input vec_t v);
        exp_t e;
        @(negedge clk);
        cur     = v;
        e.id    = id;
        e.stall = v.stall;
        e.exb   = v.exb;
        e.memb  = v.memb;
        e.cyc   = exp_cnt;
        sb.push_back(e);
        #1;
        check_a();
        if (!v.rstn) exp_cnt = '0;
        else if (v.stall != 6'd0 && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic apply_b(input int id, input vec_t v);
        @(negedge clk);
        cur = v;
        #1;
        tests++;
        if (bus_b.stall !== v.stall || bus_b.ex_bubble !== v.exb || bus_b.mem_bubble !== v.memb) begin
            fails++;
            $display("FAIL lat3_step%0d: got stall=%b exb=%b memb=%b, required stall=%b exb=%b memb=%b",
                     id, bus_b.stall, bus_b.ex_bubble, bus_b.mem_bubble, v.stall, v.exb, v.memb);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle;
        idle = mk(1,0, 0,0,0,0, 0,0,0, 0,0,0, 0, 0,0,0);
        cur  = idle;
        cur.rstn = 1'b0;
        repeat (2) @(posedge clk);
        exp_cnt = '0;

        // rstn flush re1 ra1 re2 ra2 exw exa exl memw mema meml busy | stall exb memb
        tbl.push_back(mk(0,0, 0,0,1,5, 1,5,1, 0,0,0, 0, 0, 0,0));   // reset forces outputs low
        tbl.push_back(idle);
        tbl.push_back(mk(1,0, 0,0,1,5, 1,5,1, 0,0,0, 0, LU,1,0));   // EX load r5, port 2
        tbl.push_back(mk(1,0, 0,0,0,0, 0,0,0, 0,0,0, 0, LU,1,0));   // LU_WAIT
        tbl.push_back(idle);
        tbl.push_back(mk(1,0, 1,5,0,0, 0,0,0, 1,5,1, 0, LU,1,0));   // MEM load r5: one cycle
        tbl.push_back(idle);
        tbl.push_back(mk(1,0, 1,0,1,0, 0,0,0, 1,0,1, 0, 0, 0,0));   // r0 never matches
        tbl.push_back(mk(1,0, 0,5,0,5, 1,5,1, 1,5,1, 0, 0, 0,0));   // read enables low
        tbl.push_back(mk(1,0, 1,7,0,0, 1,7,0, 0,0,0, 0, 0, 0,0));   // EX ALU result: bypassable
        tbl.push_back(mk(1,0, 1,4,1,4, 1,3,1, 0,0,0, 0, 0, 0,0));   // different register
        tbl.push_back(mk(1,0, 1,5,0,0, 0,0,0, 1,5,0, 0, 0, 0,0));   // MEM non-load
        tbl.push_back(mk(1,0, 1,5,0,0, 0,5,1, 0,0,0, 0, 0, 0,0));   // EX load without wreg
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1,0, 0,0,0,0, 0,0,0, 0,0,0, 1, EH,0,1)); // ex_busy 4 cycles
        tbl.push_back(idle);                                         // busy falls: released
        tbl.push_back(mk(1,0, 1,6,0,0, 1,6,1, 0,0,0, 1, EH,0,1));   // busy beats haz_ex
        tbl.push_back(mk(1,0, 1,6,0,0, 1,6,1, 0,0,0, 0, 0, 0,0));   // EX_HOLD exit cycle
        tbl.push_back(mk(1,0, 1,6,0,0, 1,6,1, 0,0,0, 0, LU,1,0));   // re-presented hazard
        tbl.push_back(mk(1,0, 0,0,0,0, 0,0,0, 0,0,0, 0, LU,1,0));
        tbl.push_back(idle);
        tbl.push_back(mk(1,0, 1,9,0,0, 1,9,1, 0,0,0, 0, LU,1,0));
        tbl.push_back(mk(1,1, 0,0,0,0, 0,0,0, 0,0,0, 0, 0, 0,0));   // flush in LU_WAIT
        tbl.push_back(idle);                                         // back in IDLE
        tbl.push_back(mk(1,1, 1,9,0,0, 1,9,1, 0,0,0, 0, 0, 0,0));   // flush beats haz_ex
        tbl.push_back(mk(1,1, 0,0,0,0, 0,0,0, 0,0,0, 1, 0, 0,0));   // flush beats ex_busy
        tbl.push_back(mk(1,0, 1,9,0,0, 1,9,1, 0,0,0, 0, LU,1,0));   // IDLE, not EX_HOLD
        tbl.push_back(mk(1,0, 0,0,0,0, 0,0,0, 0,0,0, 0, LU,1,0));
        tbl.push_back(idle);

        foreach (tbl[i]) apply(i, tbl[i]);

        // Reset while held by a multi-cycle EX op.
        apply(100, mk(1,0, 0,0,0,0, 0,0,0, 0,0,0, 1, EH,0,1));
        apply(101, mk(1,0, 0,0,0,0, 0,0,0, 0,0,0, 1, EH,0,1));
        apply(102, mk(0,0, 0,0,0,0, 0,0,0, 0,0,0, 1, 0, 0,0));
        apply(103, mk(1,0, 1,8,0,0, 1,8,1, 0,0,0, 0, LU,1,0));
        apply(104, idle_with_stall(idle));
        apply(105, idle);

        // Counter saturation from a preloaded value near the top.
        @(negedge clk);
        force dut_a.stall_cycles_q = 32'hFFFF_FFFD;
        #1;
        release dut_a.stall_cycles_q;
        exp_cnt = 32'hFFFF_FFFD;
        for (int i = 0; i < 4; i++)
            apply(200 + i, mk(1,0, 0,0,0,0, 0,0,0, 0,0,0, 1, EH,0,1));
        apply(204, idle);

        // LOAD_LAT=3 instance: EX-stage load stalls 3 cycles, MEM-stage load 2.
        apply_b(0, mk(1,1, 0,0,0,0, 0,0,0, 0,0,0, 0, 0, 0,0));
        apply_b(1, mk(1,0, 0,0,1,12, 1,12,1, 0,0,0, 0, LU,1,0));
        apply_b(2, idle_with_stall(idle));
        apply_b(3, idle_with_stall(idle));
        apply_b(4, idle);
        apply_b(5, mk(1,0, 1,12,0,0, 0,0,0, 1,12,1, 0, LU,1,0));
        apply_b(6, idle_with_stall(idle));
        apply_b(7, idle);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    function automatic vec_t idle_with_stall(input vec_t v);
        vec_t r;
        r       = v;
        r.stall = 6'b000111;
        r.exb   = 1'b1;
        r.memb  = 1'b0;
        return r;
    endfunction

endmodule
